// File: rtl/pmp_pkg.sv
// pmp_pkg -- shared types and helpers for the PMP match-result output stage.
//
// Contents:
//   PMP_DW        data width the FIFO entry struct and sat_abs are built for
//   pmp_entry_t   packed FIFO entry {tuser, tlast, data}
//   invalid_disp  INVALID_DISP pattern (-2^(w-1)) for a given width w
//   sat_abs       saturating absolute value of a two's-complement word
package pmp_pkg;

    // Width of the packed entry and of sat_abs. The packer's DATA_WIDTH
    // defaults to this value and must be kept equal to it.
    localparam int PMP_DW = 16;

    typedef struct packed {
        logic              tuser;
        logic              tlast;
        logic [PMP_DW-1:0] data;
    } pmp_entry_t;

    // Most negative two's-complement value of width w, in the low w bits.
    function automatic logic [63:0] invalid_disp(input int unsigned w);
        invalid_disp = 64'd1 << (w - 1);
    endfunction

    // |v| with the single unrepresentable case (most negative value)
    // clamped to the most positive value.
    function automatic logic [PMP_DW-1:0] sat_abs(input logic [PMP_DW-1:0] v);
        logic [PMP_DW-1:0] neg;
        neg = ~v + 1'b1;
        if (!v[PMP_DW-1])
            sat_abs = v;
        else if (v == {1'b1, {(PMP_DW-1){1'b0}}})
            sat_abs = {1'b0, {(PMP_DW-1){1'b1}}};
        else
            sat_abs = neg;
    endfunction

endpackage

// File: rtl/match_fifo.sv
// match_fifo -- synchronous first-word-fall-through FIFO.
//
// The head entry is visible on rd_data_o whenever empty_o is low. A write
// presented while full is accepted only if a read happens in the same cycle;
// otherwise it is discarded and drop_o is high for that cycle.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the FIFO)
//   wr_en_i      write request, wr_data_i the entry to store
//   rd_en_i      read request (ignored while empty)
//   rd_data_o    head entry, zero while empty
//   empty_o      no entries stored
//   drop_o       a write request was discarded this cycle
module match_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_rd;
    logic w_wr;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_rd    = rd_en_i && !w_empty;
    // On full, a same-cycle read frees the slot the write lands in.
    assign w_wr    = wr_en_i && (!w_full || w_rd);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= wr_data_i;
    end

    assign rd_data_o = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty_o   = w_empty;
    assign drop_o    = wr_en_i && w_full && !w_rd;

endmodule

// File: rtl/match_result_packer.sv
// match_result_packer -- qualifies best-match results from the compare tree
// against an error threshold, converts position to disparity, tags line and
// frame boundaries and emits them as AXI4-Stream through a small FIFO (the
// compare tree cannot be stalled, so results that find the FIFO full are
// dropped and flagged).
//
// Optional feature: define MATCH_STAT_EN to add per-frame match/miss counters
// (match_cnt_o, miss_cnt_o).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   error_i, pos_i, vld_i    signed phase error / column position, one pixel per vld_i
//   err_th                   unsigned acceptance threshold
//   m_axis_*                 output stream: tdata disparity or INVALID_DISP,
//                            tlast = last pixel of line, tuser = first pixel of frame
//   ovf_o                    sticky: a result was dropped on a full FIFO
//   frame_done_o             pulse while the stage register holds a frame's last pixel
//   match_cnt_o, miss_cnt_o  per-frame counts (MATCH_STAT_EN only)
//
// Handshake: a beat transfers on a clock edge where m_axis_tvalid and
// m_axis_tready are both high; while tvalid is high and tready low the beat
// (tdata/tlast/tuser) is held unchanged.
module match_result_packer
    import pmp_pkg::*;
#(
    parameter int DATA_WIDTH = PMP_DW,
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] error_i,
    input  logic [DATA_WIDTH-1:0] pos_i,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] err_th,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  ovf_o,
    output logic                  frame_done_o
`ifdef MATCH_STAT_EN
    ,
    output logic [31:0]           match_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [DATA_WIDTH-1:0] INVALID_DISP = DATA_WIDTH'(invalid_disp(DATA_WIDTH));

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_vld;
    logic                  r_match;
    logic                  r_frame_last;
    logic                  r_ovf;
    pmp_entry_t            r_entry;

    logic                  w_col_last;
    logic                  w_row_last;
    logic [DATA_WIDTH-1:0] w_abs_err;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] w_disp;
    pmp_entry_t            w_head;
    logic                  w_empty;
    logic                  w_drop;

    assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_abs_err  = sat_abs(error_i);
    assign w_match    = (w_abs_err <= err_th);
    // Plain modular subtraction: disparity wraps rather than saturates.
    assign w_disp     = pos_i - DATA_WIDTH'(r_col);

    // Coordinates advance for every pixel, including ones later dropped,
    // so downstream markers stay aligned with the image geometry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (vld_i) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Stage 1: the qualified pixel, written to the FIFO on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld        <= 1'b0;
            r_match      <= 1'b0;
            r_frame_last <= 1'b0;
            r_entry      <= '0;
        end else begin
            r_vld <= vld_i;
            if (vld_i) begin
                r_match       <= w_match;
                r_frame_last  <= w_col_last && w_row_last;
                r_entry.data  <= w_match ? w_disp : INVALID_DISP;
                r_entry.tuser <= (r_col == '0) && (r_row == '0);
                r_entry.tlast <= w_col_last;
            end
        end
    end

    match_fifo #(
        .WIDTH ($bits(pmp_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (r_vld),
        .wr_data_i (r_entry),
        .rd_en_i   (m_axis_tready),
        .rd_data_o (w_head),
        .empty_o   (w_empty),
        .drop_o    (w_drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
    end

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_head.data;
    assign m_axis_tlast  = w_head.tlast;
    assign m_axis_tuser  = w_head.tuser;
    assign ovf_o         = r_ovf;
    assign frame_done_o  = r_vld && r_frame_last;

`ifdef MATCH_STAT_EN
    logic [31:0] r_match_cnt;
    logic [31:0] r_miss_cnt;
    logic [31:0] w_match_next;
    logic [31:0] w_miss_next;

    // Saturating increments; the current pixel is folded in before a
    // frame-end snapshot so the last pixel of the frame is counted.
    assign w_match_next = (r_match  && (r_match_cnt != '1)) ? r_match_cnt + 1'b1 : r_match_cnt;
    assign w_miss_next  = (!r_match && (r_miss_cnt  != '1)) ? r_miss_cnt  + 1'b1 : r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            match_cnt_o <= '0;
            miss_cnt_o  <= '0;
        end else if (r_vld) begin
            if (r_frame_last) begin
                match_cnt_o <= w_match_next;
                miss_cnt_o  <= w_miss_next;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
            end else begin
                r_match_cnt <= w_match_next;
                r_miss_cnt  <= w_miss_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_match_result_packer.sv
// Testbench for match_result_packer (DATA_WIDTH=16, 4x2 image, 4-deep FIFO).
module tb_match_result_packer;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int IH = 2;
    localparam int FD = 4;
    localparam int EW = DW + 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] error_i;
    logic [DW-1:0] pos_i;
    logic          vld_i;
    logic [DW-1:0] err_th;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          ovf_o;
    logic          frame_done_o;
`ifdef MATCH_STAT_EN
    logic [31:0]   match_cnt_o;
    logic [31:0]   miss_cnt_o;
`endif

    match_result_packer #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .error_i       (error_i),
        .pos_i         (pos_i),
        .vld_i         (vld_i),
        .err_th        (err_th),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .ovf_o         (ovf_o),
        .frame_done_o  (frame_done_o)
`ifdef MATCH_STAT_EN
        ,
        .match_cnt_o   (match_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and check ----------------
    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Beat layout {tuser, tlast, tdata}.
    function automatic logic [EW-1:0] ref_entry(input int col, input int row,
                                                input logic [DW-1:0] err,
                                                input logic [DW-1:0] pos,
                                                input logic [DW-1:0] th);
        int e;
        int a;
        logic [DW-1:0] d;
        logic u;
        logic l;
        e = int'($signed(err));
        a = (e < 0) ? -e : e;
        if (a > 32767) a = 32767;
        if (a <= int'(th)) d = DW'(int'(pos) - col);
        else               d = 16'h8000;
        u = (col == 0) && (row == 0);
        l = (col == IW - 1);
        return {u, l, d};
    endfunction

    logic [EW-1:0] exp_q[$];   // model FIFO contents
    logic [EW-1:0] got_q[$];   // every beat accepted by the sink
    int            fd_cnt;

    always @(posedge clk) begin : sb
        logic          p_vld;
        logic          p_rdy;
        logic          p_tv;
        logic          p_rst;
        logic [DW-1:0] p_err;
        logic [DW-1:0] p_pos;
        logic [DW-1:0] p_th;
        logic [EW-1:0] p_beat;
        logic          pop;
        int            sz;
        static logic          m_stg_vld = 1'b0;
        static logic [EW-1:0] m_stg = '0;
        static logic          m_stg_fl = 1'b0;
        static int            m_col = 0;
        static int            m_row = 0;
        static logic          m_ovf = 1'b0;

        p_vld  = vld_i;
        p_rdy  = m_axis_tready;
        p_tv   = m_axis_tvalid;
        p_rst  = rst;
        p_err  = error_i;
        p_pos  = pos_i;
        p_th   = err_th;
        p_beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        if (!p_rst && p_tv && p_rdy) got_q.push_back(p_beat);
        if (!p_rst && frame_done_o) fd_cnt++;
        #1;
        if (rst) begin
            exp_q.delete();
            m_stg_vld = 1'b0;
            m_col     = 0;
            m_row     = 0;
            m_ovf     = 1'b0;
        end else begin
            sz  = exp_q.size();
            pop = (sz > 0) && p_rdy;
            if (pop) void'(exp_q.pop_front());
            if (m_stg_vld) begin
                if (sz < FD || pop) exp_q.push_back(m_stg);
                else                m_ovf = 1'b1;
            end
            m_stg_vld = p_vld;
            if (p_vld) begin
                m_stg    = ref_entry(m_col, m_row, p_err, p_pos, p_th);
                m_stg_fl = (m_col == IW - 1) && (m_row == IH - 1);
                m_col++;
                if (m_col == IW) begin
                    m_col = 0;
                    m_row = (m_row == IH - 1) ? 0 : m_row + 1;
                end
            end
            check("sb_tvalid", m_axis_tvalid, exp_q.size() > 0);
            if (exp_q.size() > 0)
                check("sb_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q[0]);
            check("sb_ovf", ovf_o, m_ovf);
            check("sb_frame_done", frame_done_o, m_stg_vld && m_stg_fl);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        vld_i = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
    endtask

    task automatic drive(input logic [DW-1:0] err, input logic [DW-1:0] pos);
        @(negedge clk);
        vld_i   = 1'b1;
        error_i = err;
        pos_i   = pos;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld_i = 1'b0;
        end
    endtask

    // Waits (bounded) until n beats past index base have been accepted.
    task automatic wait_beats(input string name, input int base, input int n);
        for (int i = 0; i < 40 && got_q.size() < base + n; i++) @(negedge clk);
        check(name, got_q.size() - base, n);
    endtask

    task automatic check_beat(input string name, input int idx, input logic [EW-1:0] exp);
        if (idx < got_q.size()) check(name, got_q[idx], exp);
        else                    check(name, 32'hDEAD_BEEF, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] err;
        logic [DW-1:0] pos;
        logic [DW-1:0] th;
        logic [EW-1:0] exp;   // {tuser, tlast, tdata}
    } vec_t;

    vec_t tab[12];

    // ---------------- main sequence ----------------
    initial begin
        int gb;
        int fd0;
        n_pass        = 0;
        n_total       = 0;
        rst           = 1'b1;
        vld_i         = 1'b0;
        error_i       = '0;
        pos_i         = '0;
        err_th        = 16'd10;
        m_axis_tready = 1'b1;

        tab[0]  = '{16'd10,   16'd3,      16'd10, {1'b1, 1'b0, 16'h0003}};
        tab[1]  = '{16'hFFF5, 16'd4,      16'd10, {1'b0, 1'b0, 16'h8000}};
        tab[2]  = '{16'h8000, 16'd5,      16'd10, {1'b0, 1'b0, 16'h8000}};
        tab[3]  = '{16'hFFF6, 16'd3,      16'd10, {1'b0, 1'b1, 16'h0000}};
        tab[4]  = '{16'd0,    16'd0,      16'd10, {1'b0, 1'b0, 16'h0000}};
        tab[5]  = '{16'd11,   16'd1,      16'd10, {1'b0, 1'b0, 16'h8000}};
        tab[6]  = '{16'h7FFF, 16'd2,      16'd10, {1'b0, 1'b0, 16'h8000}};
        tab[7]  = '{16'd0,    16'd0,      16'd10, {1'b0, 1'b1, 16'hFFFD}};
        tab[8]  = '{16'd0,    16'h7FFF,   16'd10, {1'b1, 1'b0, 16'h7FFF}};
        tab[9]  = '{16'd0,    16'h8000,   16'd10, {1'b0, 1'b0, 16'h7FFF}};
        tab[10] = '{16'd5,    16'd9,      16'd4,  {1'b0, 1'b0, 16'h8000}};
        tab[11] = '{16'd4,    16'd9,      16'd4,  {1'b0, 1'b1, 16'h0006}};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_frame_done", frame_done_o, 0);
`ifdef MATCH_STAT_EN
        check("rst_match_cnt", match_cnt_o, 0);
        check("rst_miss_cnt", miss_cnt_o, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Single pixel latency: tvalid exactly 2 edges after vld_i is sampled
        gb = got_q.size();
        drive(16'd5, 16'd7);
        @(posedge clk); #2;
        check("lat_one_edge_tvalid", m_axis_tvalid, 0);
        @(negedge clk);
        vld_i = 1'b0;
        @(posedge clk); #2;
        check("lat_two_edge_tvalid", m_axis_tvalid, 1);
        check("lat_tdata", m_axis_tdata, 16'd7);
        check("lat_tuser", m_axis_tuser, 1);
        check("lat_tlast", m_axis_tlast, 0);
        idle(3);
        check("lat_drained", got_q.size() - gb, 1);

        // Table: threshold, saturation, wrap, threshold change
        do_reset();
        gb = got_q.size();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            err_th = tab[i].th;
            vld_i  = 1'b1;
            error_i = tab[i].err;
            pos_i   = tab[i].pos;
        end
        idle(1);
        err_th = 16'd10;
        wait_beats("tab_count", gb, 12);
        for (int i = 0; i < 12; i++) check_beat("tab_beat", gb + i, tab[i].exp);

        // 9 consecutive beats with pos = col + 2
        do_reset();
        gb  = got_q.size();
        fd0 = fd_cnt;
        for (int i = 0; i < 9; i++) drive(16'd0, DW'((i % IW) + 2));
        idle(1);
        wait_beats("frame_count", gb, 9);
        idle(2);
        check("frame_done_pulses", fd_cnt - fd0, 1);
        for (int i = 0; i < 9; i++)
            check_beat("frame_beat", gb + i,
                       {(i == 0 || i == 8) ? 1'b1 : 1'b0, (i % IW == IW - 1) ? 1'b1 : 1'b0, 16'd2});

        // Overflow: tready low, 6 beats into a 4-deep FIFO
        do_reset();
        gb = got_q.size();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) drive(16'd0, 16'd10);
        idle(3);
        check("ovf_set", ovf_o, 1);
        check("ovf_tvalid_held", m_axis_tvalid, 1);
        check("ovf_head_held", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, {1'b1, 1'b0, 16'd10});
        m_axis_tready = 1'b1;
        wait_beats("ovf_count", gb, 4);
        check_beat("ovf_b0", gb + 0, {1'b1, 1'b0, 16'd10});
        check_beat("ovf_b1", gb + 1, {1'b0, 1'b0, 16'd9});
        check_beat("ovf_b2", gb + 2, {1'b0, 1'b0, 16'd8});
        check_beat("ovf_b3", gb + 3, {1'b0, 1'b1, 16'd7});
        drive(16'd0, 16'd10);    // dropped beats advanced coordinates: col 2 row 1
        idle(1);
        wait_beats("ovf_after_count", gb, 5);
        check_beat("ovf_after", gb + 4, {1'b0, 1'b0, 16'd8});
        check("ovf_sticky", ovf_o, 1);

        // Full FIFO with a read and a write on the same edge
        do_reset();
        gb = got_q.size();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) drive(16'd0, DW'(20 + i));
        @(negedge clk);
        m_axis_tready = 1'b1;
        vld_i   = 1'b1;
        error_i = 16'd0;
        pos_i   = 16'd25;
        idle(1);
        wait_beats("full_rw_count", gb, 6);
        check("full_rw_no_ovf", ovf_o, 0);
        for (int i = 0; i < 6; i++)
            check_beat("full_rw_beat", gb + i,
                       {(i == 0) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0, DW'(20 + i - (i % IW))});

        // Reset mid-frame flushes the FIFO and restarts at pixel (0,0)
        do_reset();
        m_axis_tready = 1'b0;
        drive(16'd0, 16'd30);
        drive(16'd0, 16'd31);
        idle(3);
        check("midrst_before", m_axis_tvalid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        check("midrst_empty", m_axis_tvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        gb = got_q.size();
        drive(16'd0, 16'd5);
        idle(1);
        wait_beats("midrst_count", gb, 1);
        check_beat("midrst_beat", gb, {1'b1, 1'b0, 16'd5});

`ifdef MATCH_STAT_EN
        // One frame of 3 matches and 5 misses
        do_reset();
        for (int i = 0; i < 8; i++)
            drive((i == 0 || i == 2 || i == 5) ? 16'd0 : 16'd100, 16'd0);
        idle(4);
        check("stat_match", match_cnt_o, 3);
        check("stat_miss", miss_cnt_o, 5);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            vld_i = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 3) == 0) error_i = DW'($urandom());
            else                           error_i = DW'($urandom_range(0, 40) - 20);
            pos_i = DW'($urandom());
            if ($urandom_range(0, 15) == 0) err_th = DW'($urandom_range(0, 30));
            m_axis_tready = ($urandom_range(0, 99) < 60);
        end
        @(negedge clk);
        rst           = 1'b0;
        m_axis_tready = 1'b1;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
